// File: rtl/seq_mul16_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the default operand width.
package seq_mul16_pkg;

  localparam int DEF_N = 16;
  localparam int ST_W  = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul16_add2n_comb.sv
// Pure combinational W-bit adder returning sum and carry-out; the multiplier
// feeds it the running partial product and the shifted multiplicand.
module add2n_comb
  import seq_mul16_pkg::*;
#(
  parameter int W = 2 * DEF_N
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/seq_mul16.sv
// Sequential unsigned N x N -> 2N multiplier, one conditional add per clock,
// with a start/busy/done handshake and fixed latency of N+1 cycles to done.
module seq_mul16
  import seq_mul16_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2*N-1:0]   r_acc;
  logic [2*N-1:0]   r_mcand;
  logic [2*N-1:0]   r_product;
  logic [N-1:0]     r_mplier;
  logic [CW-1:0]    r_cnt;
  logic [2*N-1:0]   w_sum;
  logic [2*N-1:0]   w_acc_nxt;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;

  add2n_comb #(.W(2 * N)) u_add (
    .i_a    (r_acc),
    .i_b    (r_mcand),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // DONE accepts start just like IDLE, which gives back-to-back operation.
  assign w_accept  = start && (r_state != ST_RUN);
  assign w_last    = (r_state == ST_RUN) && (r_cnt == CW'(N - 1));
  assign w_acc_nxt = r_mplier[0] ? w_sum : r_acc;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so an abandoned operation
  // leaves no stale partial product or count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{N{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_product <= w_acc_nxt;
    end
  end

  assign busy    = (r_state == ST_RUN);
  assign done    = (r_state == ST_DONE);
  assign product = r_product;

  // The partial product never exceeds 2N bits for unsigned operands.
  a_cout_zero: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_RUN && r_mplier[0]) |-> !w_cout);

endmodule
